// File: rtl/serial_sub_pkg.sv
// Purpose: shared types and sizing helpers for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_sub_pkg;

  // Sequencer states: accept operands, walk the bits, present the result.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  // Supported operand widths.
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bit-counter width for a given operand width. The counter only ever
  // holds WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_w(input int width);
    return (width < MIN_WIDTH) ? 1 : $clog2(width);
  endfunction

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// Purpose: one-bit full subtractor cell computing a - b - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshakes.
//
// Ports:
//   a    minuend bit
//   b    subtrahend bit
//   bin  borrow in from the less significant bit
//   d    difference bit
//   bout borrow out to the more significant bit
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d = a ^ b ^ bin;

  // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when
  // the two bits are equal and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial a - b, LSB first, through one full-subtractor cell.
// Latency: result valid WIDTH cycles after the input handshake.
// Backpressure: result held in DONE until out_ready; in_ready low until then.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   a, b              minuend / subtrahend, sampled on the input handshake
//   out_valid/out_ready result handshake
//   diff              (a - b) mod 2^WIDTH
//   borrow            1 iff a < b as unsigned values
//   ovf               two's-complement overflow of a - b
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = cnt_w(WIDTH);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 difference bits already produced; the final bit comes
  // straight from the cell on the last SHIFT cycle.
  logic [WIDTH-2:0] r_sr;
  logic [CNT_W-1:0] cnt;
  logic             bq;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;
  logic             ovf_next;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bq),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // New difference bit enters at the MSB and everything moves right by one.
  assign r_next   = {cell_d, r_sr};
  assign last_bit = (cnt == '0);

  // On the last SHIFT cycle a_sr[0]/b_sr[0] are the operand sign bits and
  // cell_d is the result sign bit. Overflow: signs of a and b differ and the
  // result sign differs from the sign of a.
  assign ovf_next = (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      cnt       <= '0;
      bq        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            r_sr     <= '0;
            bq       <= 1'b0;
            cnt      <= CNT_W'(WIDTH - 1);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next[WIDTH-1:1];
          bq   <= cell_bo;
          if (last_bit) begin
            // Borrow out of the MSB cell is the unsigned borrow of a - b.
            diff      <= r_next;
            borrow    <= cell_bo;
            ovf       <= ovf_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          // diff/borrow/ovf are not written here, so they stay frozen until
          // the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is a registered copy of "state is IDLE".
  a_in_ready_idle : assert property (
    @(posedge clk) disable iff (!rst_n) in_ready == (state == IDLE)
  );

  // A stalled result keeps out_valid high and its payload unchanged.
  a_hold_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(diff) &&
                                     $stable(borrow) && $stable(ovf))
  );

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Purpose: self-checking bench for serial_subtractor with a queue scoreboard.
// Latency: checks WIDTH-cycle result latency and WIDTH+2 initiation interval.
// Backpressure: exercises held out_ready low, random out_ready, busy inputs.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    int   ux, uy, sx, sy, sd;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    sd = sx - sy;
    r.d  = W'((ux - uy + 256) % 256);
    r.bo = (ux < uy);
    r.ov = (sd > 127) || (sd < -128);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the oldest
  // outstanding expectation; it is retired only when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        chk("result", {22'b0, diff, borrow, ovf}, {22'b0, sb[0]});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive a pair until it is accepted; optionally scramble a/b while busy.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit scramble, input res_t want, output int acc);
    int tries = 0;
    bit done = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    while (!done && tries < 200) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      if (in_ready) begin
        a = x;
        b = y;
        @(posedge clk);
        sb.push_back(want);
        #1;
        acc  = cyc;
        done = 1'b1;
      end else begin
        if (scramble) begin
          a = W'($urandom);
          b = W'($urandom);
        end
        @(posedge clk);
        #1;
        tries++;
      end
    end
    if (!done) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(0), 32'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_diff"},      32'(diff),      32'(0));
    chk({tag, "_borrow"},    32'(borrow),    32'(0));
    chk({tag, "_ovf"},       32'(ovf),       32'(0));
  endtask

  logic [W-1:0] dir_a [4] = '{8'h05, 8'h03, 8'h80, 8'h00};
  logic [W-1:0] dir_b [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
  res_t         dir_e [4] = '{{8'h02, 1'b0, 1'b0},
                              {8'hFE, 1'b1, 1'b0},
                              {8'h7F, 1'b0, 1'b1},
                              {8'h01, 1'b1, 1'b0}};

  initial begin
    int   acc, acc1, acc2, n, seen;
    logic [W-1:0] x, y;

    // Reset state, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors; first one also measures latency.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(dir_a[i], dir_b[i], 1'b0, dir_e[i], acc);
      in_valid = 1'b0;
      wait_out(n);
      if (i == 0) chk("latency", 32'(n), 32'(W));
      @(posedge clk);
      #1;
    end

    // Backpressure: stall the result for 5 cycles.
    out_ready = 1'b0;
    issue(8'h33, 8'h11, 1'b0, model(8'h33, 8'h11), acc);
    in_valid = 1'b0;
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready_low", 32'(in_ready), 32'(0));
      chk("bp_out_valid_held", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_out_valid_dropped", 32'(out_valid), 32'(0));
    chk("bp_in_ready_back", 32'(in_ready), 32'(1));

    // Busy-ignore: in_valid held high and a/b scrambled during SHIFT.
    issue(8'h5A, 8'hA5, 1'b0, model(8'h5A, 8'hA5), acc1);
    issue(8'h12, 8'h34, 1'b1, model(8'h12, 8'h34), acc2);
    in_valid = 1'b0;
    chk("initiation_interval", 32'(acc2 - acc1), 32'(W + 2));
    wait_out(n);
    @(posedge clk);
    #1;

    // Reset 3 cycles into SHIFT; in-flight result must vanish.
    issue(8'h77, 8'h22, 1'b0, model(8'h77, 8'h22), acc);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    if (sb.size() > 0) void'(sb.pop_back());
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("no_stale_result", 32'(seen), 32'(0));
    issue(8'h10, 8'h01, 1'b0, '{8'h0F, 1'b0, 1'b0}, acc);
    in_valid = 1'b0;
    wait_out(n);
    @(posedge clk);
    #1;

    // Random traffic with random out_ready and random input gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      issue(x, y, 1'($urandom_range(0, 1)), model(x, y), acc);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_rdy  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart to the team's adder cells. It trades WIDTH cycles of latency for one-bit datapath logic. Operands enter and the result leaves over valid/ready handshakes, so the block drops into any streaming arithmetic path.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand pair `a`/`b` is valid.
- `in_ready`  output  1  block can accept operands (high only in IDLE).
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `out_valid`  output  1  `diff`/`borrow`/`ovf` are valid.
- `out_ready`  input  1  downstream accepts the result.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  output  1  unsigned borrow: 1 iff `a < b` unsigned.
- `ovf`  output  1  signed overflow: operand sign bits differ and `diff` sign differs from `a` sign.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid & in_ready`: latch `a` and `b` into shift registers, clear the borrow flop, load the bit counter with `WIDTH-1`, go to SHIFT.
- **SHIFT**, one bit per clock:
  - Cell inputs are `a_sr[0]`, `b_sr[0]`, `bq`.
  - Cell outputs: `d = a ^ b ^ bq`; `bo = (~a & b) | (~(a ^ b) & bq)`.
  - `d` shifts into the MSB of the result register (right shift). `bo` is written to `bq`. The operand registers shift right.
  - The sign bits of `a` and `b` are captured on the last bit for `ovf`.
  - When the counter is 0: go to DONE; `borrow` takes `bo` of the MSB cycle.
- **DONE**
  - `out_valid=1`. `diff`, `borrow` and `ovf` are held stable.
  - On `out_ready`: go to IDLE.
- `in_valid` outside IDLE is ignored. Operands are not sampled, and `a`/`b` changes have no effect.
- `out_ready` outside DONE is ignored.
- All arithmetic is modulo 2^WIDTH. No sign extension and no saturation.

## Timing
- Reset value of every output: `in_ready=1`, `out_valid=0`, `diff=0`, `borrow=0`, `ovf=0`. FSM is in IDLE, counter=0, `bq=0`.
- Latency: if the input handshake occurs at edge E, `out_valid` rises after edge E+WIDTH (WIDTH SHIFT edges).
- `out_valid` stays high and the outputs stay frozen until the edge where `out_ready=1`.
- After the output handshake edge, `in_ready=1` from the next cycle.
- Minimum initiation interval is WIDTH+2 cycles, with `out_ready` tied high.
- `in_ready` is a registered function of state only. It has no combinational path from `out_ready`.
- `out_valid`, `diff`, `borrow` and `ovf` come from flops.
- Reset asserted mid-SHIFT or mid-DONE:
  - Immediately abort to IDLE with all outputs at their reset values.
  - The in-flight result is discarded and never presented.
- `in_valid` held high continuously: the next operand pair is accepted on the first IDLE cycle only.

## Structure
- Package `serial_sub_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t`.
  - Counter width as the constant `CNT_W = $clog2(WIDTH)`, declared as a function of the parameter.
- One sub-module: `full_subtractor` (`a`, `b`, `bin` -> `d`, `bout`). It is purely combinational and instantiated once.
- The top module holds:
  - the FSM
  - the counter
  - the operand and result shift registers
  - the borrow flop
  - the output registers

## Test plan
All scenarios use WIDTH=8.
- Reset check: assert `rst_n=0` -> `in_ready=1`, `out_valid=0`, `diff=0x00`, `borrow=0`, `ovf=0`.
- Basic subtract and latency: `a=0x05`, `b=0x03` -> `diff=0x02`, `borrow=0`, `ovf=0`, with `out_valid` exactly 8 edges after acceptance.
- Wrap-around and signed overflow:
  - `a=0x03`, `b=0x05` -> `diff=0xFE`, `borrow=1`, `ovf=0`.
  - `a=0x80`, `b=0x01` -> `diff=0x7F`, `borrow=0`, `ovf=1`.
  - `a=0x00`, `b=0xFF` -> `diff=0x01`, `borrow=1`, `ovf=0`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` -> outputs stable and `in_ready=0` throughout. The result is consumed on the first `out_ready=1` edge, and `in_ready=1` the next cycle.
- Busy-ignore: change `a`/`b` with `in_valid=1` during SHIFT -> the result matches the originally accepted pair. The next pair is accepted only after returning to IDLE.
- Reset mid-operation: pulse `rst_n` low 3 cycles into SHIFT -> outputs return to reset values immediately and no `out_valid` is ever seen. A subsequent pair `0x10`/`0x01` -> `diff=0x0F`, `borrow=0`, `ovf=0`.
